// File: rtl/mini_risc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mini_risc_pkg
//  Description : Shared definitions for the MINI-RISC core: field widths,
//                the NOP encoding and small instruction-field helpers used
//                by the fetch/decode control, hazard unit and decoder.
//  Revision    : 1.0  initial release
// ============================================================================
package mini_risc_pkg;

    localparam int OPCODE_W = 5;
    localparam int REG_W    = 3;
    localparam int INSTR_W  = 16;
    localparam int PC_W     = 8;

    // The all-zeros word decodes as a no-operation; a killed IF/ID slot
    // carries this value so decode never sees stale instruction bits.
    localparam logic [INSTR_W-1:0] NOP = '0;

    // Opcode values with front-end significance.
    typedef enum logic [OPCODE_W-1:0] {
        OP_NOP  = 5'd0,
        OP_LOAD = 5'd1,
        OP_STOR = 5'd2,
        OP_BEQ  = 5'd8,
        OP_BNE  = 5'd9,
        OP_JMP  = 5'd10
    } opcode_e;

    // Instruction layout: [15:11] opcode, [10:8] rd, [7:5] rs1, [4:0] imm.
    typedef struct packed {
        logic [OPCODE_W-1:0] opcode;
        logic [REG_W-1:0]    rd;
        logic [REG_W-1:0]    rs1;
        logic [4:0]          imm;
    } instr_fields_t;

    function automatic instr_fields_t split_instr(input logic [INSTR_W-1:0] instr);
        return instr_fields_t'(instr);
    endfunction

    function automatic logic is_control_xfer(input logic [INSTR_W-1:0] instr);
        instr_fields_t f;
        f = split_instr(instr);
        return (f.opcode == OP_BEQ) || (f.opcode == OP_BNE) || (f.opcode == OP_JMP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Event counter that saturates at all-ones. A clear has
//                priority over an increment in the same cycle.
//  Ports       : clk, rst (sync, active-high), clr, inc -> cnt[CNT_W-1:0]
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_at_max;

    assign w_at_max = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !w_at_max) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule
`default_nettype wire

// File: rtl/fetch_decode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode_ctrl
//  Description : Front-end pipeline control. Owns the PC, the IF/ID register
//                and the ID/EX valid bit, turning hazard-unit stall, flush
//                and redirect decisions into held, killed or bubbled
//                instructions. Keeps saturating stall/flush event counters.
//  Ports       : clk, rst                      clock, sync active-high reset
//                stall_F, stall_D              hold PC / hold IF/ID
//                flush_F, flush_D              kill fetch / kill decode slot
//                redirect_valid, redirect_pc   taken branch/jump target
//                imem_rdata                    instruction at pc_F
//                cnt_clr                       clear both event counters
//                pc_F                          fetch address
//                instr_D, pc_D, valid_D        IF/ID register contents
//                valid_E                       ID/EX live flag
//                stall_cnt, flush_cnt          saturating event counters
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_decode_ctrl #(
    parameter int                      PC_W     = mini_risc_pkg::PC_W,
    parameter int                      INSTR_W  = mini_risc_pkg::INSTR_W,
    parameter logic [PC_W-1:0]         RESET_PC = '0,
    parameter int                      CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall_F,
    input  logic               stall_D,
    input  logic               flush_F,
    input  logic               flush_D,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               cnt_clr,
    output logic [PC_W-1:0]    pc_F,
    output logic [INSTR_W-1:0] instr_D,
    output logic [PC_W-1:0]    pc_D,
    output logic               valid_D,
    output logic               valid_E,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    import mini_risc_pkg::*;

    localparam logic [INSTR_W-1:0] C_NOP = INSTR_W'(NOP);

    // ------------------------------------------------------------------
    // PC register
    // ------------------------------------------------------------------
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;

    // A redirect is only honoured when decode is free to advance: a branch
    // stalled on a load-use operand has not really resolved yet, and the
    // hazard unit will present the redirect again once the stall clears.
    always_comb begin
        pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};   // wraps naturally at all-ones
        if (stall_F) begin
            pc_d = pc_q;
        end else if (redirect_valid && !stall_D) begin
            pc_d = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    logic [INSTR_W-1:0] instr_D_q;
    logic [INSTR_W-1:0] instr_D_d;
    logic [PC_W-1:0]    pc_D_q;
    logic [PC_W-1:0]    pc_D_d;
    logic               valid_D_q;
    logic               valid_D_d;

    // Stall beats flush: a killed fetch is retried on the first unstalled
    // cycle because the hazard unit keeps the flush asserted. A flushed slot
    // still records pc_F so the bubble's address is meaningful for debug.
    always_comb begin
        instr_D_d = imem_rdata;
        pc_D_d    = pc_q;
        valid_D_d = 1'b1;
        if (stall_D) begin
            instr_D_d = instr_D_q;
            pc_D_d    = pc_D_q;
            valid_D_d = valid_D_q;
        end else if (flush_F) begin
            instr_D_d = C_NOP;
            pc_D_d    = pc_q;
            valid_D_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instr_D_q <= C_NOP;
            pc_D_q    <= '0;
            valid_D_q <= 1'b0;
        end else begin
            instr_D_q <= instr_D_d;
            pc_D_q    <= pc_D_d;
            valid_D_q <= valid_D_d;
        end
    end

    // ------------------------------------------------------------------
    // ID/EX valid bit
    // ------------------------------------------------------------------
    // Every stalled decode cycle sends exactly one bubble downstream; a
    // flushed decode instruction (branch/jump completes in decode, or a
    // wrong-path instruction) never reaches execute.
    logic valid_E_q;
    logic valid_E_d;

    assign valid_E_d = valid_D_q && !stall_D && !flush_D;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_E_q <= 1'b0;
        end else begin
            valid_E_q <= valid_E_d;
        end
    end

    // ------------------------------------------------------------------
    // Event counters
    // ------------------------------------------------------------------
    // A flush only counts when it actually kills a fetch, i.e. when the
    // fetch stage is not being held that cycle.
    logic w_stall_evt;
    logic w_flush_evt;

    assign w_stall_evt = stall_D;
    assign w_flush_evt = flush_F && !stall_F;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (w_stall_evt),
        .cnt (stall_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (w_flush_evt),
        .cnt (flush_cnt)
    );

    // ------------------------------------------------------------------
    // Outputs: straight from registers
    // ------------------------------------------------------------------
    assign pc_F    = pc_q;
    assign instr_D = instr_D_q;
    assign pc_D    = pc_D_q;
    assign valid_D = valid_D_q;
    assign valid_E = valid_E_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_decode_ctrl
//  Description : Self-checking bench for fetch_decode_ctrl. Directed vector
//                table plus hand-written reset and counter-saturation
//                sequences.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_decode_ctrl;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 16;
    localparam int CNT_W   = 16;

    logic               clk;
    logic               rst;
    logic               stall_F, stall_D, flush_F, flush_D;
    logic               redirect_valid;
    logic [PC_W-1:0]    redirect_pc;
    logic [INSTR_W-1:0] imem_rdata;
    logic               cnt_clr;
    logic [PC_W-1:0]    pc_F;
    logic [INSTR_W-1:0] instr_D;
    logic [PC_W-1:0]    pc_D;
    logic               valid_D;
    logic               valid_E;
    logic [CNT_W-1:0]   stall_cnt;
    logic [CNT_W-1:0]   flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_decode_ctrl #(
        .PC_W     (PC_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (8'h00),
        .CNT_W    (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_F        (stall_F),
        .stall_D        (stall_D),
        .flush_F        (flush_F),
        .flush_D        (flush_D),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_rdata     (imem_rdata),
        .cnt_clr        (cnt_clr),
        .pc_F           (pc_F),
        .instr_D        (instr_D),
        .pc_D           (pc_D),
        .valid_D        (valid_D),
        .valid_E        (valid_E),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory pattern: upper byte is the inverted address.
    function automatic logic [INSTR_W-1:0] imem_pat(input logic [PC_W-1:0] p);
        return {~p, p};
    endfunction

    assign imem_rdata = imem_pat(pc_F);

    typedef struct {
        logic            sF, sD, fF, fD, rv, clr;
        logic [PC_W-1:0] rpc;
        logic [PC_W-1:0] e_pc;
        logic [15:0]     e_instr;
        logic [PC_W-1:0] e_pcD;
        logic            e_vD, e_vE;
        logic [15:0]     e_sc, e_fc;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic sF, sD, fF, fD, rv, input logic [7:0] rpc,
                       input logic clr, input logic [7:0] e_pc,
                       input logic [15:0] e_instr, input logic [7:0] e_pcD,
                       input logic e_vD, e_vE, input logic [15:0] e_sc, e_fc);
        vec_t v;
        v.sF = sF; v.sD = sD; v.fF = fF; v.fD = fD; v.rv = rv; v.rpc = rpc;
        v.clr = clr; v.e_pc = e_pc; v.e_instr = e_instr; v.e_pcD = e_pcD;
        v.e_vD = e_vD; v.e_vE = e_vE; v.e_sc = e_sc; v.e_fc = e_fc;
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic sF, sD, fF, fD, rv, input logic [7:0] rpc,
                         input logic clr);
        stall_F = sF; stall_D = sD; flush_F = fF; flush_D = fD;
        redirect_valid = rv; redirect_pc = rpc; cnt_clr = clr;
    endtask

    task automatic check_all(input int idx, input logic [7:0] e_pc,
                             input logic [15:0] e_instr, input logic [7:0] e_pcD,
                             input logic e_vD, e_vE, input logic [15:0] e_sc, e_fc);
        check("pc_F",      idx, 32'(pc_F),      32'(e_pc));
        check("instr_D",   idx, 32'(instr_D),   32'(e_instr));
        check("pc_D",      idx, 32'(pc_D),      32'(e_pcD));
        check("valid_D",   idx, 32'(valid_D),   32'(e_vD));
        check("valid_E",   idx, 32'(valid_E),   32'(e_vE));
        check("stall_cnt", idx, 32'(stall_cnt), 32'(e_sc));
        check("flush_cnt", idx, 32'(flush_cnt), 32'(e_fc));
    endtask

    initial begin
        // ---------------- vector table ----------------
        // Free run from reset: pc 0 -> 5, valid_E one cycle behind valid_D.
        add(0,0,0,0,0,8'h00,0, 8'h01, imem_pat(8'h00), 8'h00, 1,0, 0,0);
        for (int p = 2; p <= 5; p++)
            add(0,0,0,0,0,8'h00,0, 8'(p), imem_pat(8'(p-1)), 8'(p-1), 1,1, 0,0);
        // Two-cycle stall at pc_F=5: everything held, two bubbles.
        add(1,1,0,0,0,8'h00,0, 8'h05, imem_pat(8'h04), 8'h04, 1,0, 1,0);
        add(1,1,0,0,0,8'h00,0, 8'h05, imem_pat(8'h04), 8'h04, 1,0, 2,0);
        // Resume to pc_F=0x10.
        for (int p = 6; p <= 16; p++)
            add(0,0,0,0,0,8'h00,0, 8'(p), imem_pat(8'(p-1)), 8'(p-1), 1,1, 2,0);
        // Redirect to 0x40 with flush of both stages.
        add(0,0,1,1,1,8'h40,0, 8'h40, 16'h0000, 8'h10, 0,0, 2,1);
        add(0,0,0,0,0,8'h00,0, 8'h41, imem_pat(8'h40), 8'h40, 1,0, 2,1);
        add(0,0,0,0,0,8'h00,0, 8'h42, imem_pat(8'h41), 8'h41, 1,1, 2,1);
        // Redirect+flush under stall: held, then taken on the next cycle.
        add(1,1,1,1,1,8'h80,0, 8'h42, imem_pat(8'h41), 8'h41, 1,0, 3,1);
        add(0,0,1,1,1,8'h80,0, 8'h80, 16'h0000, 8'h42, 0,0, 3,2);
        add(0,0,0,0,0,8'h00,0, 8'h81, imem_pat(8'h80), 8'h80, 1,0, 3,2);
        // Free run through the PC wrap 0xFF -> 0x00 -> 0x01.
        for (int p = 16'h82; p <= 16'h101; p++)
            add(0,0,0,0,0,8'h00,0, 8'(p), imem_pat(8'(p-1)), 8'(p-1), 1,1, 3,2);
        // Counter clear.
        add(0,0,0,0,0,8'h00,1, 8'h02, imem_pat(8'h01), 8'h01, 1,1, 0,0);

        // ---------------- reset ----------------
        drive(0,0,0,0,0,8'h00,0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all(-1, 8'h00, 16'h0000, 8'h00, 0,0, 0,0);
        rst = 1'b0;

        // ---------------- table run ----------------
        foreach (tbl[i]) begin
            drive(tbl[i].sF, tbl[i].sD, tbl[i].fF, tbl[i].fD, tbl[i].rv,
                  tbl[i].rpc, tbl[i].clr);
            @(posedge clk);
            #1;
            check_all(i, tbl[i].e_pc, tbl[i].e_instr, tbl[i].e_pcD,
                      tbl[i].e_vD, tbl[i].e_vE, tbl[i].e_sc, tbl[i].e_fc);
        end

        // ---------------- reset in the middle of stall/flush/redirect ----------------
        drive(1,1,1,1,1,8'hC0,0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_all(1000, 8'h00, 16'h0000, 8'h00, 0,0, 0,0);
        // Release with a redirect still presented but stalled: no jump.
        rst = 1'b0;
        drive(1,1,0,0,1,8'hC0,0);

        // ---------------- stall counter saturation ----------------
        repeat ((1 << CNT_W) + 3) @(posedge clk);
        #1;
        check("stall_cnt_sat", 2000, 32'(stall_cnt), 32'h0000_FFFF);
        check("pc_F_held",     2000, 32'(pc_F),      32'h0);
        check("valid_E_stall", 2000, 32'(valid_E),   32'h0);
        drive(1,1,0,0,0,8'h00,1);
        @(posedge clk);
        #1;
        check("stall_cnt_clr", 2001, 32'(stall_cnt), 32'h0);
        drive(1,1,0,0,0,8'h00,0);
        @(posedge clk);
        #1;
        check("stall_cnt_after_clr", 2002, 32'(stall_cnt), 32'h1);
        check("flush_cnt_idle",      2002, 32'(flush_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
